// File: rtl/lc2k_pkg.sv
// Shared definitions for the LC2K multi-cycle core: opcodes, FSM states, field positions.
package lc2k_pkg;

  typedef enum logic [2:0] {
    ADD  = 3'd0,
    NOR  = 3'd1,
    LW   = 3'd2,
    SW   = 3'd3,
    BEQ  = 3'd4,
    JALR = 3'd5,
    HALT = 3'd6,
    NOOP = 3'd7
  } opcode_e;

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    EXEC    = 3'd2,
    MEM     = 3'd3,
    WB      = 3'd4,
    HALT_ST = 3'd5
  } state_e;

  // Instruction field positions; only bits [24:0] of a word carry meaning.
  localparam int unsigned FIELD_W  = 3;
  localparam int unsigned OPC_LSB  = 22;
  localparam int unsigned REGA_LSB = 19;
  localparam int unsigned REGB_LSB = 16;
  localparam int unsigned DEST_LSB = 0;
  localparam int unsigned OFF_W    = 16;
  localparam int unsigned INSTR_W  = 25;
  localparam int unsigned NUM_REGS = 8;

endpackage

// File: rtl/lc2k_regfile.sv
// Eight-entry register file: two read ports, one write port, debug read, reg0 tied to zero.
module lc2k_regfile
  import lc2k_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [2:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [2:0]        ra,
  input  logic [2:0]        rb,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  // Synchronous clear; writes to reg0 are dropped so it never leaves zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we && (waddr != 3'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  // Combinational reads with reg0 forced to zero.
  always_comb begin
    rdata_a  = (ra == 3'd0) ? '0 : regs_q[ra];
    rdata_b  = (rb == 3'd0) ? '0 : regs_q[rb];
    dbg_data = (dbg_sel == 3'd0) ? '0 : regs_q[dbg_sel];
  end

endmodule

// File: rtl/lc2k_multicycle_core.sv
// Multi-cycle LC2K core with one shared req/ready memory port and retire counting.
module lc2k_multicycle_core
  import lc2k_pkg::*;
#(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  state_e              state_q;
  logic [ADDR_W-1:0]   pc_q;
  logic [INSTR_W-1:0]  ir_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   alu_q;  // ALU result, or effective address for lw/sw
  logic [DATA_W-1:0]   mdr_q;
  logic                halted_q;
  logic [31:0]         count_q;

  opcode_e             opc;
  logic [2:0]          rega;
  logic [2:0]          regb;
  logic [2:0]          dest;
  logic [DATA_W-1:0]   offset_sext;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W-1:0]   link;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;

  logic                rf_we;
  logic [2:0]          rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;

  assign opc         = opcode_e'(ir_q[OPC_LSB +: FIELD_W]);
  assign rega        = ir_q[REGA_LSB +: FIELD_W];
  assign regb        = ir_q[REGB_LSB +: FIELD_W];
  assign dest        = ir_q[DEST_LSB +: FIELD_W];
  assign offset_sext = {{(DATA_W - OFF_W){ir_q[OFF_W-1]}}, ir_q[OFF_W-1:0]};
  assign pc_inc      = pc_q + ADDR_W'(1);

  // Zero-extended return address for jalr.
  always_comb begin
    link               = '0;
    link[ADDR_W-1:0]   = pc_inc;
  end

  // Memory port; gated by rst_n so nothing is requested while reset is held.
  assign mem_req   = rst_n && ((state_q == FETCH) || (state_q == MEM));
  assign mem_we    = rst_n && (state_q == MEM) && (opc == SW);
  assign mem_addr  = (state_q == MEM) ? alu_q[ADDR_W-1:0] : pc_q;
  assign mem_wdata = b_q;

  assign pc          = pc_q;
  assign halted      = halted_q;
  assign instr_count = count_q;

  // Register write port: jalr links in EXEC, everything else writes back in WB.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dest;
    rf_wdata = alu_q;
    if ((state_q == EXEC) && (opc == JALR)) begin
      rf_we    = 1'b1;
      rf_waddr = regb;
      rf_wdata = link;
    end else if (state_q == WB) begin
      rf_we = 1'b1;
      if (opc == LW) begin
        rf_waddr = regb;
        rf_wdata = mdr_q;
      end
    end
  end

  lc2k_regfile #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (rf_waddr),
    .wdata    (rf_wdata),
    .ra       (rega),
    .rb       (regb),
    .dbg_sel  (dbg_sel),
    .rdata_a  (rd_a),
    .rdata_b  (rd_b),
    .dbg_data (dbg_data)
  );

  // Main control FSM with PC, IR, operand latches, halt flag and retire counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      alu_q    <= '0;
      mdr_q    <= '0;
      halted_q <= 1'b0;
      count_q  <= '0;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata[INSTR_W-1:0];
            state_q <= DECODE;
          end
        end
        DECODE: begin
          a_q <= rd_a;
          b_q <= rd_b;
          if (opc == HALT) begin
            // Halt retires here and the PC steps past it.
            halted_q <= 1'b1;
            pc_q     <= pc_inc;
            count_q  <= count_q + 32'd1;
            state_q  <= HALT_ST;
          end else begin
            state_q <= EXEC;
          end
        end
        EXEC: begin
          case (opc)
            ADD: begin
              alu_q   <= a_q + b_q;
              state_q <= WB;
            end
            NOR: begin
              alu_q   <= ~(a_q | b_q);
              state_q <= WB;
            end
            LW, SW: begin
              alu_q   <= a_q + offset_sext;
              state_q <= MEM;
            end
            BEQ: begin
              pc_q    <= (a_q == b_q) ? (pc_inc + offset_sext[ADDR_W-1:0]) : pc_inc;
              count_q <= count_q + 32'd1;
              state_q <= FETCH;
            end
            JALR: begin
              // a_q was captured in DECODE, so regA==regB jumps to the old value.
              pc_q    <= a_q[ADDR_W-1:0];
              count_q <= count_q + 32'd1;
              state_q <= FETCH;
            end
            default: begin
              pc_q    <= pc_inc;
              count_q <= count_q + 32'd1;
              state_q <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (mem_ready) begin
            if (opc == SW) begin
              pc_q    <= pc_inc;
              count_q <= count_q + 32'd1;
              state_q <= FETCH;
            end else begin
              mdr_q   <= mem_rdata;
              state_q <= WB;
            end
          end
        end
        WB: begin
          pc_q    <= pc_inc;
          count_q <= count_q + 32'd1;
          state_q <= FETCH;
        end
        HALT_ST: begin
          state_q <= HALT_ST;
        end
        default: begin
          state_q <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lc2k_multicycle_core.sv
// Scoreboard bench for lc2k_multicycle_core: instruction-level model predicts memory traffic,
// final architectural state and cycle count; a monitor checks each accepted transfer.
module tb_lc2k_multicycle_core;

  localparam int DW = 32;
  localparam int AW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } xfer_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] pc;
  logic          halted;
  logic [31:0]   instr_count;
  logic [2:0]    dbg_sel = 3'd0;
  logic [DW-1:0] dbg_data;

  always #5 clk = ~clk;

  lc2k_multicycle_core #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .RESET_PC (16'h0000)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .pc          (pc),
    .halted      (halted),
    .instr_count (instr_count),
    .dbg_sel     (dbg_sel),
    .dbg_data    (dbg_data)
  );

  logic [31:0] tb_mem  [65536];
  logic [31:0] iss_mem [65536];

  int n_checks = 0;
  int n_errors = 0;
  xfer_t exp_q[$];

  int waited = 0, cur_wait = 0, wait_mode = 0;
  int wait_cycles = 0, write_hs = 0, hold_w = 0, last_cycles = 0;
  logic req_was = 1'b0, hs_was = 1'b0, stall_was = 1'b0;
  logic [AW-1:0] s_addr;
  logic          s_we;
  logic [DW-1:0] s_wdata;

  // Reference model results
  logic [31:0] m_regs [8];
  logic [15:0] m_pc;
  int          m_count, m_base;
  logic        m_halted;

  assign mem_rdata = tb_mem[mem_addr];
  assign mem_ready = mem_req && (waited >= cur_wait);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic int pick_wait();
    case (wait_mode)
      0:       return 0;
      1:       return int'($urandom_range(0, 2));
      2:       return 3;
      default: return 50;
    endcase
  endfunction

  // Monitor: observes the bus between clock edges, checks transfers and stability.
  always @(negedge clk) begin
    if (mem_req && stall_was) begin
      n_checks++;
      if (mem_addr !== s_addr || mem_we !== s_we || mem_wdata !== s_wdata) begin
        n_errors++;
        $display("FAIL hold_stable: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                 mem_addr, mem_we, mem_wdata, s_addr, s_we, s_wdata);
      end
    end
    if (mem_req && mem_we && mem_addr == 16'd8 && mem_wdata == 32'h1234) hold_w++;
    if (mem_req && mem_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL xfer_unexpected: got addr=%h we=%b, expected no transfer", mem_addr, mem_we);
      end else begin
        xfer_t x;
        x = exp_q.pop_front();
        if (mem_addr !== x.addr || mem_we !== x.we || (x.we && mem_wdata !== x.wdata)) begin
          n_errors++;
          $display("FAIL xfer: got addr=%h we=%b wdata=%h, expected addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, x.addr, x.we, x.wdata);
        end
      end
      if (mem_we) begin
        tb_mem[mem_addr] = mem_wdata;
        write_hs++;
      end
    end else if (mem_req) begin
      wait_cycles++;
    end
    stall_was = mem_req && !mem_ready;
    s_addr    = mem_addr;
    s_we      = mem_we;
    s_wdata   = mem_wdata;
    req_was   = mem_req;
    hs_was    = mem_req && mem_ready;
  end

  // Wait-state generator: each new request waits cur_wait cycles before ready.
  always @(posedge clk) begin
    #1;
    if (!req_was || hs_was) begin
      waited   = 0;
      cur_wait = pick_wait();
    end else begin
      waited++;
    end
  end

  function automatic logic [31:0] enc_r(input int op, input int a, input int b, input int d);
    return 32'((op << 22) | (a << 19) | (b << 16) | d);
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int a, input int b, input int off);
    return 32'((op << 22) | (a << 19) | (b << 16) | (off & 'hFFFF));
  endfunction

  task automatic load(input int addr, input logic [31:0] val);
    tb_mem[addr]  = val;
    iss_mem[addr] = val;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) load(i, 32'h0);
  endtask

  // Instruction-level reference: executes the program, queues expected bus transfers.
  task automatic iss_run();
    logic [31:0] r [8];
    logic [31:0] ins, sx, ea, t;
    logic [15:0] p;
    int op, a, b, d, steps;
    xfer_t x;
    for (int i = 0; i < 8; i++) r[i] = 32'h0;
    p = 16'h0; m_count = 0; m_base = 0; m_halted = 1'b0; steps = 0;
    while (!m_halted && steps < 5000) begin
      ins = iss_mem[p];
      x.addr = p; x.we = 1'b0; x.wdata = 32'h0;
      exp_q.push_back(x);
      op = int'(ins[24:22]); a = int'(ins[21:19]); b = int'(ins[18:16]); d = int'(ins[2:0]);
      sx = {{16{ins[15]}}, ins[15:0]};
      ea = r[a] + sx;
      m_count++;
      case (op)
        0: begin if (d != 0) r[d] = r[a] + r[b]; p = p + 16'd1; m_base += 4; end
        1: begin if (d != 0) r[d] = ~(r[a] | r[b]); p = p + 16'd1; m_base += 4; end
        2: begin
          x.addr = ea[15:0]; x.we = 1'b0; x.wdata = 32'h0;
          exp_q.push_back(x);
          if (b != 0) r[b] = iss_mem[ea[15:0]];
          p = p + 16'd1; m_base += 5;
        end
        3: begin
          x.addr = ea[15:0]; x.we = 1'b1; x.wdata = r[b];
          exp_q.push_back(x);
          iss_mem[ea[15:0]] = r[b];
          p = p + 16'd1; m_base += 4;
        end
        4: begin
          p = (r[a] == r[b]) ? (p + 16'd1 + sx[15:0]) : (p + 16'd1);
          m_base += 3;
        end
        5: begin
          t = r[a];
          if (b != 0) r[b] = {16'h0, p + 16'd1};
          p = t[15:0]; m_base += 3;
        end
        6: begin p = p + 16'd1; m_halted = 1'b1; m_base += 2; end
        default: begin p = p + 16'd1; m_base += 3; end
      endcase
      steps++;
    end
    for (int i = 0; i < 8; i++) m_regs[i] = r[i];
    m_pc = p;
  endtask

  // Reset, predict, release and run to halt, then compare final state with the model.
  task automatic run_prog(input string tag, input int max_cycles);
    int cycles;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    check({tag, ".rst_req"}, 32'(mem_req), 32'd0);
    check({tag, ".rst_pc"}, 32'(pc), 32'd0);
    exp_q.delete();
    iss_run();
    wait_cycles = 0; write_hs = 0; hold_w = 0;
    rst_n = 1'b1;
    #1;
    check({tag, ".first_fetch"}, {30'd0, mem_req, mem_we}, {30'd0, 1'b1, 1'b0});
    check({tag, ".first_addr"}, 32'(mem_addr), 32'd0);
    cycles = 0;
    while (!halted && cycles < max_cycles) begin
      @(posedge clk); #1;
      cycles++;
    end
    last_cycles = cycles;
    check({tag, ".halted"}, 32'(halted), 32'd1);
    check({tag, ".pc"}, 32'(pc), 32'(m_pc));
    check({tag, ".instr_count"}, instr_count, 32'(m_count));
    check({tag, ".cycles"}, 32'(cycles), 32'(m_base + wait_cycles));
    check({tag, ".queue_drained"}, 32'(exp_q.size()), 32'd0);
    for (int i = 0; i < 8; i++) begin
      dbg_sel = 3'(i);
      #1;
      check($sformatf("%s.r%0d", tag, i), dbg_data, m_regs[i]);
    end
  endtask

  task automatic reg_chk(input string name, input int idx, input logic [31:0] exp);
    dbg_sel = 3'(idx);
    #1;
    check(name, dbg_data, exp);
  endtask

  task automatic mid_mem_reset();
    xfer_t x;
    bit found;
    clear_mem();
    load(0, enc_i(2, 0, 1, 5));
    load(5, 32'd7);
    wait_mode = 3;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    exp_q.delete();
    x.addr = 16'd0; x.we = 1'b0; x.wdata = 32'h0;
    exp_q.push_back(x);
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (mem_req && mem_addr == 16'd5) begin
        found = 1'b1;
        break;
      end
    end
    check("midmem.reached", 32'(found), 32'd1);
    check("midmem.stalled", 32'(mem_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midmem.req_dropped", 32'(mem_req), 32'd0);
    check("midmem.pc", 32'(pc), 32'd0);
    check("midmem.instr_count", instr_count, 32'd0);
    check("midmem.halted", 32'(halted), 32'd0);
    reg_chk("midmem.r1", 1, 32'd0);
    check("midmem.queue", 32'(exp_q.size()), 32'd0);
    wait_mode = 0;
  endtask

  task automatic rand_prog(input int n);
    int op, base;
    logic [31:0] w;
    clear_mem();
    for (int k = 1; k < 8; k++) load(k - 1, enc_i(2, 0, k, 64 + k));
    for (int k = 64; k < 128; k++) load(k, $urandom);
    base = 7;
    for (int i = 0; i < n; i++) begin
      op = int'($urandom_range(0, 7));
      if (op == 5) op = 0;
      if (op == 6) op = 2;
      case (op)
        0, 1: w = enc_r(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 7)));
        2, 3: w = enc_i(op, 0, int'($urandom_range(0, 7)), 64 + int'($urandom_range(0, 63)));
        4:    w = enc_i(4, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                        int'($urandom_range(0, 3)));
        default: w = {10'd0, 3'd7, 19'($urandom)};
      endcase
      load(base + i, w | ($urandom & 32'hFE00_0000));
    end
    for (int i = 0; i < 5; i++) load(base + n + i, enc_i(6, 0, 0, 0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // lw/add/halt, zero-wait
    wait_mode = 0;
    clear_mem();
    load(0, 32'h0081_0005);
    load(1, 32'h0009_0002);
    load(2, 32'h0180_0000);
    load(5, 32'd7);
    run_prog("basic", 200);
    check("basic.cycles11", 32'(last_cycles), 32'd11);
    check("basic.count3", instr_count, 32'd3);
    check("basic.pc3", 32'(pc), 32'd3);
    reg_chk("basic.r1_7", 1, 32'd7);
    reg_chk("basic.r2_14", 2, 32'd14);

    // beq countdown loop, plus a not-taken branch with offset -1
    wait_mode = 1;
    clear_mem();
    load(0, enc_i(2, 0, 1, 30));
    load(1, enc_i(2, 0, 2, 31));
    load(2, enc_i(4, 1, 0, 2));
    load(3, enc_r(0, 1, 2, 1));
    load(4, enc_i(4, 0, 0, 'hFFFD));
    load(5, enc_i(4, 1, 2, 'hFFFF));
    load(6, enc_i(6, 0, 0, 0));
    load(30, 32'd3);
    load(31, 32'hFFFF_FFFF);
    run_prog("beq", 1000);
    reg_chk("beq.r1_zero", 1, 32'd0);
    check("beq.count", instr_count, 32'd14);
    check("beq.pc", 32'(pc), 32'd7);

    // jalr 1 1 at pc=4 with r1=9
    wait_mode = 0;
    clear_mem();
    load(0, enc_i(2, 0, 1, 20));
    for (int i = 1; i < 4; i++) load(i, enc_i(7, 0, 0, 0));
    load(4, enc_i(5, 1, 1, 0));
    for (int i = 5; i < 10; i++) load(i, enc_i(6, 0, 0, 0));
    load(20, 32'd9);
    run_prog("jalr", 200);
    reg_chk("jalr.r1_5", 1, 32'd5);
    check("jalr.pc", 32'(pc), 32'd10);

    // sw under three wait states per request
    wait_mode = 2;
    clear_mem();
    load(0, enc_i(2, 0, 1, 20));
    load(1, enc_i(3, 0, 1, 8));
    load(2, enc_i(6, 0, 0, 0));
    load(20, 32'h1234);
    run_prog("sw_wait", 400);
    check("sw_wait.mem8", tb_mem[8], 32'h1234);
    check("sw_wait.one_write", 32'(write_hs), 32'd1);
    check("sw_wait.hold_cycles", 32'(hold_w), 32'd4);

    // write to reg0 is discarded
    wait_mode = 0;
    clear_mem();
    load(0, enc_i(2, 0, 1, 20));
    load(1, enc_r(0, 1, 1, 0));
    load(2, enc_i(6, 0, 0, 0));
    load(20, 32'd3);
    run_prog("reg0", 200);
    reg_chk("reg0.r0", 0, 32'd0);
    reg_chk("reg0.r1", 1, 32'd3);

    mid_mem_reset();

    // randomized programs
    for (int t = 0; t < 8; t++) begin
      wait_mode = int'($urandom_range(0, 1));
      rand_prog(24);
      run_prog($sformatf("rand%0d", t), 5000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
